// File: rtl/uart_tx_fifo.sv
// Console transmit buffer: bus-written bytes are queued and drained to the
// uarttx serializer over its charin/txen/busy handshake; the CPU never stalls.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int BUSYTO = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wen,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic       ren,
  input  logic [1:0] raddr,
  output logic [7:0] rdata,
  output logic [7:0] charout,
  output logic       txen,
  input  logic       uartbusy,
  output logic       empty,
  output logic       full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (BUSYTO > 1) ? $clog2(BUSYTO) : 1;
  localparam logic [4:0]    DEPTH_C = 5'(DEPTH);
  localparam logic [TW-1:0] TO_LAST = TW'(BUSYTO - 1);

  typedef enum logic [1:0] {IDLE, SEND, RISE, FALL} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [4:0]    count, count_nxt;
  logic          overflow;
  logic [TW-1:0] tcnt;

  logic push_req, push, pop, flush, oclr;

  // full is the registered flag, so a push on a full FIFO is dropped even if
  // the drain pops in the same cycle.
  always_comb begin
    push_req = wen && (waddr == 2'd0);
    push     = push_req && !full;
    flush    = wen && (waddr == 2'd1) && wdata[0];
    oclr     = wen && (waddr == 2'd1) && wdata[1];
    pop      = (state == IDLE) && !empty && !uartbusy;
    count_nxt = count;
    if (flush)
      count_nxt = 5'd0;
    else if (push && !pop)
      count_nxt = count + 5'd1;
    else if (!push && pop)
      count_nxt = count - 5'd1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= 5'd0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
      rdata    <= 8'h00;
    end else begin
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
      end
      count <= count_nxt;
      empty <= (count_nxt == 5'd0);
      full  <= (count_nxt == DEPTH_C);
      // Set beats clear when both land in the same cycle.
      if (push_req && full)
        overflow <= 1'b1;
      else if (oclr)
        overflow <= 1'b0;
      if (ren)
        rdata <= (raddr == 2'd0) ? {count, overflow, full, empty} : 8'h00;
    end
  end

  // Drain FSM. A missing busy response past BUSYTO cycles still consumes the
  // character; there is no retry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      charout <= 8'h00;
      txen    <= 1'b0;
      tcnt    <= '0;
    end else begin
      txen <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          charout <= mem[rptr];
          txen    <= 1'b1;
          state   <= SEND;
        end
        SEND: begin
          tcnt  <= '0;
          state <= RISE;
        end
        RISE: begin
          if (uartbusy)
            state <= FALL;
          else if (tcnt == TO_LAST)
            state <= IDLE;
          else
            tcnt <= tcnt + 1'b1;
        end
        FALL: if (!uartbusy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  a_count_range: assert property (@(posedge clk) disable iff (rst) count <= DEPTH_C);
  a_txen_send:   assert property (@(posedge clk) disable iff (rst) txen == (state == SEND));

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: register-map vector table plus hand-written
// drain, overflow, flush, timeout and reset sequences against a uarttx model.
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       rst, wen, ren, uartbusy;
  logic [1:0] waddr, raddr;
  logic [7:0] wdata, rdata, charout;
  logic       txen, empty, full;

  uart_tx_fifo #(.DEPTH(16), .BUSYTO(4)) dut (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rdata), .charout(charout), .txen(txen),
    .uartbusy(uartbusy), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // uarttx model: 0 = hold at hold_lvl, 1 = busy for busy_len after txen, 2 = never busy
  int   busy_mode = 0, busy_len = 3, bcnt = 0;
  logic hold_lvl = 1'b0;
  always @(negedge clk) begin
    case (busy_mode)
      0: uartbusy = hold_lvl;
      1: if (txen) begin
           uartbusy = 1'b1; bcnt = busy_len;
         end else if (bcnt > 0) begin
           bcnt = bcnt - 1; uartbusy = (bcnt != 0);
         end else uartbusy = 1'b0;
      default: uartbusy = 1'b0;
    endcase
  end

  logic [7:0] tx_q[$];
  int         tx_cyc[$];
  always @(negedge clk) if (txen) begin
    tx_q.push_back(charout);
    tx_cyc.push_back(cyc);
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk); wen = 1'b1; waddr = a; wdata = d;
    @(negedge clk); wen = 1'b0;
  endtask

  task automatic rd_status(output logic [7:0] v);
    @(negedge clk); ren = 1'b1; raddr = 2'd0;
    @(negedge clk); ren = 1'b0; v = rdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic       wen;
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic       ren;
    logic [1:0] raddr;
    logic [7:0] e_rdata;
    logic       e_empty;
    logic       e_full;
  } vec_t;
  vec_t vt[13];

  logic [7:0] st;

  initial begin
    // Register-map vectors, applied with the uart held busy so nothing drains.
    vt[0]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 8'h01, 1'b1, 1'b0};
    vt[1]  = '{1'b1, 2'd0, 8'hAA, 1'b0, 2'd0, 8'h01, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 8'h08, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'h00, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 2'd2, 8'h55, 1'b1, 2'd0, 8'h08, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 2'd3, 8'hFF, 1'b1, 2'd0, 8'h08, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 2'd0, 8'h11, 1'b1, 2'd0, 8'h08, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 8'h10, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 2'd1, 8'h02, 1'b1, 2'd0, 8'h10, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'h00, 1'b0, 1'b0};
    vt[10] = '{1'b1, 2'd1, 8'h01, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0};
    vt[11] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 8'h01, 1'b1, 1'b0};
    vt[12] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 8'h00, 1'b1, 1'b0};

    rst = 1'b1; wen = 1'b0; ren = 1'b0; waddr = 2'd0; raddr = 2'd0; wdata = 8'h00;
    busy_mode = 0; hold_lvl = 1'b1;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rdata", rdata, 8'h00);
    chk("reset_charout", charout, 8'h00);
    chk("reset_txen", {7'd0, txen}, 8'h00);
    chk("reset_empty", {7'd0, empty}, 8'h01);
    chk("reset_full", {7'd0, full}, 8'h00);

    for (int i = 0; i < 13; i++) begin
      wen = vt[i].wen; waddr = vt[i].waddr; wdata = vt[i].wdata;
      ren = vt[i].ren; raddr = vt[i].raddr;
      @(negedge clk);
      wen = 1'b0; ren = 1'b0;
      chk($sformatf("vec%0d_rdata", i), rdata, vt[i].e_rdata);
      chk($sformatf("vec%0d_empty", i), {7'd0, empty}, {7'd0, vt[i].e_empty});
      chk($sformatf("vec%0d_full", i), {7'd0, full}, {7'd0, vt[i].e_full});
      chk($sformatf("vec%0d_txen", i), {7'd0, txen}, 8'h00);
    end

    // Single character with a long busy response.
    tx_q.delete(); busy_len = 100; busy_mode = 1;
    idle(2);
    wr(2'd0, 8'h41);
    idle(120);
    chk("single_pulses", 8'(tx_q.size()), 8'd1);
    if (tx_q.size() > 0) chk("single_char", tx_q[0], 8'h41);
    rd_status(st); chk("single_status", st, 8'h01);

    // Overflow: 17 writes into 16 entries with the uart held busy.
    busy_mode = 0; hold_lvl = 1'b1;
    idle(2);
    for (int i = 0; i < 17; i++) wr(2'd0, 8'(i));
    rd_status(st); chk("ovf_status", st, 8'h86);
    chk("ovf_full", {7'd0, full}, 8'h01);
    tx_q.delete(); busy_len = 3; busy_mode = 1;
    idle(300);
    chk("ovf_pulses", 8'(tx_q.size()), 8'd16);
    for (int i = 0; i < 16 && i < tx_q.size(); i++)
      chk($sformatf("ovf_char%0d", i), tx_q[i], 8'(i));
    rd_status(st); chk("ovf_sticky", st, 8'h05);
    wr(2'd1, 8'h02);
    rd_status(st); chk("ovf_cleared", st, 8'h01);

    // Flush of a queue that has not started draining.
    busy_mode = 0; hold_lvl = 1'b1;
    idle(2);
    for (int i = 0; i < 5; i++) wr(2'd0, 8'h60 + 8'(i));
    tx_q.delete();
    wr(2'd1, 8'h01);
    rd_status(st); chk("flush_status", st, 8'h01);
    busy_mode = 1; busy_len = 3;
    idle(50);
    chk("flush_nopulse", 8'(tx_q.size()), 8'd0);

    // Flush while the first character is in FALL: it completes, rest dropped.
    tx_q.delete(); busy_len = 30;
    for (int i = 0; i < 3; i++) wr(2'd0, 8'h70 + 8'(i));
    idle(5);
    chk("fall_started", 8'(tx_q.size()), 8'd1);
    wr(2'd1, 8'h01);
    idle(80);
    chk("fall_pulses", 8'(tx_q.size()), 8'd1);
    if (tx_q.size() > 0) chk("fall_char", tx_q[0], 8'h70);
    rd_status(st); chk("fall_status", st, 8'h01);

    // uarttx never answers: each character times out, pulses 6 cycles apart.
    busy_mode = 2; tx_q.delete(); tx_cyc.delete();
    idle(2);
    for (int i = 0; i < 4; i++) wr(2'd0, 8'hC0 + 8'(i));
    idle(60);
    chk("to_pulses", 8'(tx_q.size()), 8'd4);
    for (int i = 1; i < 4 && i < tx_cyc.size(); i++)
      chk($sformatf("to_gap%0d", i), 8'(tx_cyc[i] - tx_cyc[i-1]), 8'd6);
    for (int i = 0; i < 4 && i < tx_q.size(); i++)
      chk($sformatf("to_char%0d", i), tx_q[i], 8'hC0 + 8'(i));
    chk("to_empty", {7'd0, empty}, 8'h01);

    // Reset mid-drain with three entries left and the FSM waiting in FALL.
    busy_mode = 1; busy_len = 50; tx_q.delete();
    idle(2);
    for (int i = 0; i < 4; i++) wr(2'd0, 8'hD0 + 8'(i));
    idle(3);
    rd_status(st); chk("rst_pre_status", st, 8'h18);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_empty", {7'd0, empty}, 8'h01);
    chk("rst_full", {7'd0, full}, 8'h00);
    chk("rst_txen", {7'd0, txen}, 8'h00);
    rd_status(st); chk("rst_status", st, 8'h01);
    idle(70);
    chk("rst_pulses", 8'(tx_q.size()), 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
